// File: rtl/priority_irq_pkg.sv
// Shared constants and index-code type for the priority interrupt queue.
package priority_irq_pkg;

  localparam int SRC_W = 16;
  localparam int IDX_W = 4;

  // 8-bit index code shared with the downstream encoder path: {4'b0, idx}
  typedef logic [7:0] idx_code_t;

  localparam idx_code_t IDLE_CODE = 8'hF0;

  function automatic idx_code_t make_code(input logic [IDX_W-1:0] idx);
    return {4'b0000, idx};
  endfunction

endpackage

// File: rtl/priority_encode_16.sv
// Combinational 16-input priority encoder; the highest set bit wins.
module priority_encode_16
  import priority_irq_pkg::*;
(
  input  logic [SRC_W-1:0] eligible,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // Ascending scan so the last (highest) set bit overrides lower ones
  always_comb begin
    any = |eligible;
    idx = '0;
    for (int i = 0; i < SRC_W; i++) begin
      if (eligible[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/priority_irq_queue.sv
// Rising-edge event capture, pending latch and registered valid/ready
// dispatch of the highest-numbered pending source.
// Optional feature macro: PRIO_IRQ_MASK_EN (adds the per-source mask input).
module priority_irq_queue
  import priority_irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [SRC_W-1:0] req,
  output logic             out_valid,
  input  logic             out_ready,
  output idx_code_t        out_idx,
  output logic [SRC_W-1:0] pending,
  output logic             overflow,
  input  logic             clr_ovf
`ifdef PRIO_IRQ_MASK_EN
  ,
  input  logic [SRC_W-1:0] mask
`endif
);

  logic [SRC_W-1:0] req_q;
  logic [SRC_W-1:0] req_edge;
  logic [SRC_W-1:0] eligible;
  logic [SRC_W-1:0] take;
  logic             load;
  logic             sel_any;
  logic [IDX_W-1:0] sel_idx;
  logic             ovf_set;

  assign req_edge = req & ~req_q;
  assign load     = ~out_valid | out_ready;

`ifdef PRIO_IRQ_MASK_EN
  // Masked sources keep latching but are hidden from selection
  assign eligible = pending & ~mask;
`else
  assign eligible = pending;
`endif

  priority_encode_16 u_enc (
    .eligible (eligible),
    .any      (sel_any),
    .idx      (sel_idx)
  );

  // One-hot of the source moving into the slot this cycle
  always_comb begin
    take = '0;
    if (load && sel_any) take[sel_idx] = 1'b1;
  end

  // A re-arrival on the bit being taken is a fresh event, not an overflow
  assign ovf_set = |(req_edge & pending & ~take);

  // Edge history, pending events, sticky overflow and the output slot
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= '1;
      pending   <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= IDLE_CODE;
    end else begin
      req_q   <= req;
      pending <= (pending & ~take) | req_edge;
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      if (load) begin
        if (sel_any) begin
          out_valid <= 1'b1;
          out_idx   <= make_code(sel_idx);
        end else begin
          out_valid <= 1'b0;
          out_idx   <= IDLE_CODE;
        end
      end
    end
  end

endmodule
